// File: rtl/fp16_div.sv
// rtl/fp16_div.sv - sequential binary16 divider, restoring division, truncating result
// Handshaked q = a / b with one quotient bit per cycle and one-hot class flags on q.
module fp16_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic        snan,
  output logic        qnan,
  output logic        infinity,
  output logic        zero,
  output logic        subnormal,
  output logic        normal
);

  typedef enum logic [2:0] {IDLE, UNPACK, DIV, PACK, DONE} stateT;

  stateT state, nextState;

  logic [15:0]        aReg, bReg;
  logic               sign;
  logic               special;
  logic signed [6:0]  expDiff;
  logic [11:0]        rem;
  logic [10:0]        divisor;
  logic [11:0]        quot;
  logic [3:0]         cnt;
  logic [15:0]        qReg;
  logic [5:0]         classReg;

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) lzc11 = 4'(10 - i);
    end
  endfunction

  // Returns {unbiased exponent, significand with the leading 1 at bit 10}.
  function automatic logic [17:0] normOp(input logic [14:0] x);
    logic [10:0]       raw;
    logic [3:0]        lz;
    logic signed [6:0] e;
    raw = {|x[14:10], x[9:0]};
    lz  = lzc11(raw);
    if (|x[14:10]) e = $signed({2'b00, x[14:10]}) - 7'sd15;
    else           e = -7'sd14 - $signed({3'b000, lz});
    normOp = {e, 11'(raw << lz)};
  endfunction

  // Operand classification and special-value preset
  logic              aIsNan, bIsNan, aSnan, bSnan, aQnan, bQnan;
  logic              aInf, bInf, aZero, bZero, opSign;
  logic              specialComb;
  logic [15:0]       specialQ;
  logic [5:0]        specialClass;
  logic [17:0]       aNorm, bNorm;
  logic signed [6:0] aE, bE;
  logic [10:0]       aSig, bSig;

  always_comb begin
    aIsNan = (&aReg[14:10]) && (|aReg[9:0]);
    bIsNan = (&bReg[14:10]) && (|bReg[9:0]);
    aSnan  = aIsNan && !aReg[9];
    bSnan  = bIsNan && !bReg[9];
    aQnan  = aIsNan && aReg[9];
    bQnan  = bIsNan && bReg[9];
    aInf   = (&aReg[14:10]) && !(|aReg[9:0]);
    bInf   = (&bReg[14:10]) && !(|bReg[9:0]);
    aZero  = !(|aReg[14:0]);
    bZero  = !(|bReg[14:0]);
    opSign = aReg[15] ^ bReg[15];

    specialComb  = 1'b1;
    specialQ     = 16'h0;
    specialClass = 6'b000000;
    if (aSnan || bSnan) begin
      specialQ     = aSnan ? aReg : bReg;
      specialClass = 6'b100000;
    end else if (aQnan || bQnan) begin
      specialQ     = aQnan ? aReg : bReg;
      specialClass = 6'b010000;
    end else if ((aInf && bInf) || (aZero && bZero)) begin
      specialQ     = {opSign, 5'h1F, 1'b1, 9'h02A};
      specialClass = 6'b010000;
    end else if (aInf || bZero) begin
      specialQ     = {opSign, 5'h1F, 10'h0};
      specialClass = 6'b001000;
    end else if (aZero || bInf) begin
      specialQ     = {opSign, 15'h0};
      specialClass = 6'b000100;
    end else begin
      specialComb  = 1'b0;
    end

    aNorm = normOp(aReg[14:0]);
    bNorm = normOp(bReg[14:0]);
    aE    = $signed(aNorm[17:11]);
    bE    = $signed(bNorm[17:11]);
    aSig  = aNorm[10:0];
    bSig  = bNorm[10:0];
  end

  // Result packing from the raw quotient
  logic [10:0]       packSig;
  logic [10:0]       subSig;
  logic signed [6:0] packE;
  logic [3:0]        shiftAmt;
  logic [15:0]       packQ;
  logic [5:0]        packClass;

  always_comb begin
    packSig   = quot[11] ? quot[11:1] : quot[10:0];
    packE     = quot[11] ? expDiff : expDiff - 7'sd1;
    shiftAmt  = 4'(-7'sd14 - packE);
    subSig    = packSig >> shiftAmt;
    packQ     = 16'h0;
    packClass = 6'b000000;
    if (packE < -7'sd24) begin
      packQ     = {sign, 15'h0};
      packClass = 6'b000100;
    end else if (packE < -7'sd14) begin
      packQ     = {sign, 5'h0, subSig[9:0]};
      packClass = 6'b000010;
    end else if (packE > 7'sd15) begin
      packQ     = {sign, 5'h1F, 10'h0};
      packClass = 6'b001000;
    end else begin
      packQ     = {sign, 5'(packE + 7'sd15), packSig[9:0]};
      packClass = 6'b000001;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = UNPACK;
      UNPACK:  nextState = specialComb ? PACK : DIV;
      DIV:     if (cnt == 4'd0) nextState = PACK;
      PACK:    nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aReg     <= 16'h0;
      bReg     <= 16'h0;
      sign     <= 1'b0;
      special  <= 1'b0;
      expDiff  <= 7'sd0;
      rem      <= 12'h0;
      divisor  <= 11'h0;
      quot     <= 12'h0;
      cnt      <= 4'd0;
      qReg     <= 16'h0;
      classReg <= 6'b000000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aReg <= a;
            bReg <= b;
          end
        end
        UNPACK: begin
          sign     <= opSign;
          special  <= specialComb;
          qReg     <= specialQ;
          classReg <= specialClass;
          expDiff  <= aE - bE;
          rem      <= {1'b0, aSig};
          divisor  <= bSig;
          quot     <= 12'h0;
          cnt      <= 4'd11;
        end
        DIV: begin
          // R < 2D holds throughout, so the shifted remainder never overflows 12 bits.
          if (rem >= {1'b0, divisor}) begin
            quot <= {quot[10:0], 1'b1};
            rem  <= (rem - {1'b0, divisor}) << 1;
          end else begin
            quot <= {quot[10:0], 1'b0};
            rem  <= rem << 1;
          end
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        PACK: begin
          if (!special) begin
            qReg     <= packQ;
            classReg <= packClass;
          end
        end
        default: ;
      endcase
    end
  end

  assign q = qReg;
  assign {snan, qnan, infinity, zero, subnormal, normal} = classReg & {6{out_valid}};

endmodule

// File: tb/tb_fp16_div.sv
// tb/tb_fp16_div.sv - self-checking bench for fp16_div
// Directed vectors, handshake/reset sequences and a randomized rational-arithmetic reference.
module tb_fp16_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        snan, qnan, infinity, zero, subnormal, normal;
  logic [5:0]  fl;

  int checks = 0;
  int errors = 0;

  assign fl = {snan, qnan, infinity, zero, subnormal, normal};

  always #5 clk = ~clk;

  fp16_div dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .q(q),
    .snan(snan), .qnan(qnan), .infinity(infinity), .zero(zero),
    .subnormal(subnormal), .normal(normal)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [5:0]  f;
    int          lat;
  } vecT;

  typedef struct {
    logic [15:0] q;
    logic [5:0]  f;
    int          lat;
  } resT;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // ma*2^t >= mb
  function automatic bit geq(input longint unsigned ma, input longint unsigned mb, input int t);
    if (t >= 0) return (t > 40) ? 1'b1 : ((ma << t) >= mb);
    else        return (-t > 40) ? 1'b0 : (ma >= (mb << (-t)));
  endfunction

  // Quotient as exact rational ma/mb * 2^d, truncated onto the binary16 grid.
  function automatic resT refDiv(input logic [15:0] x, input logic [15:0] y);
    resT r;
    bit xn, yn, xs, ys, xq, yq, xi, yi, xz, yz;
    logic s;
    longint unsigned ma, mb, m;
    int ea, eb, d, e, sh;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    xs = xn && !x[9];  ys = yn && !y[9];
    xq = xn && x[9];   yq = yn && y[9];
    xi = (x[14:10] == 5'h1F) && (x[9:0] == 0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == 0);
    xz = (x[14:0] == 0);
    yz = (y[14:0] == 0);
    s = x[15] ^ y[15];
    r.lat = 2;
    if (xs || ys)                  begin r.q = xs ? x : y; r.f = 6'b100000; end
    else if (xq || yq)             begin r.q = xq ? x : y; r.f = 6'b010000; end
    else if ((xi && yi) || (xz && yz)) begin r.q = {s, 15'h7E2A}; r.f = 6'b010000; end
    else if (xi || yz)             begin r.q = {s, 15'h7C00}; r.f = 6'b001000; end
    else if (xz || yi)             begin r.q = {s, 15'h0000}; r.f = 6'b000100; end
    else begin
      r.lat = 14;
      ma = (x[14:10] == 0) ? longint'(x[9:0]) : longint'({1'b1, x[9:0]});
      mb = (y[14:10] == 0) ? longint'(y[9:0]) : longint'({1'b1, y[9:0]});
      ea = (x[14:10] == 0) ? -24 : int'(x[14:10]) - 25;
      eb = (y[14:10] == 0) ? -24 : int'(y[14:10]) - 25;
      d = ea - eb;
      if (geq(ma, mb, d - 16)) begin
        r.q = {s, 15'h7C00}; r.f = 6'b001000;
      end else begin
        e = -14;
        for (int k = -14; k <= 15; k++) if (geq(ma, mb, d - k)) e = k;
        sh = d - e + 10;
        m = (sh >= 0) ? (ma << sh) / mb : ma / (mb << (-sh));
        if (m >= 1024)   begin r.q = {s, 5'(e + 15), 10'(m - 1024)}; r.f = 6'b000001; end
        else if (m == 0) begin r.q = {s, 15'h0}; r.f = 6'b000100; end
        else             begin r.q = {s, 5'h0, 10'(m)}; r.f = 6'b000010; end
      end
    end
    return r;
  endfunction

  task automatic waitResult(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
  endtask

  task automatic runOp(input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] qv, output logic [5:0] fv, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    waitResult(lat);
    qv = q;
    fv = fl;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  vecT vec[13];

  initial begin
    logic [15:0] qv, x, y;
    logic [5:0]  fv;
    int          lat, seen;
    resT         r;

    vec[0]  = '{16'h4200, 16'h3E00, 16'h4000, 6'b000001, 14};
    vec[1]  = '{16'h3C00, 16'h4200, 16'h3555, 6'b000001, 14};
    vec[2]  = '{16'h0400, 16'h4000, 16'h0200, 6'b000010, 14};
    vec[3]  = '{16'h7BFF, 16'h3800, 16'h7C00, 6'b001000, 14};
    vec[4]  = '{16'h0001, 16'h3C00, 16'h0001, 6'b000010, 14};
    vec[5]  = '{16'h3C00, 16'h0000, 16'h7C00, 6'b001000, 2};
    vec[6]  = '{16'h0000, 16'h0000, 16'h7E2A, 6'b010000, 2};
    vec[7]  = '{16'h7D00, 16'h3C00, 16'h7D00, 6'b100000, 2};
    vec[8]  = '{16'hBC00, 16'h7C00, 16'h8000, 6'b000100, 2};
    vec[9]  = '{16'h7E00, 16'h7D00, 16'h7D00, 6'b100000, 2};
    vec[10] = '{16'h7C00, 16'hFC00, 16'hFE2A, 6'b010000, 2};
    vec[11] = '{16'h0001, 16'h7BFF, 16'h0000, 6'b000100, 14};
    vec[12] = '{16'hC000, 16'h3C00, 16'hC000, 6'b000001, 14};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_flags", 32'(fl), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    foreach (vec[i]) begin
      runOp(vec[i].a, vec[i].b, qv, fv, lat);
      chk($sformatf("vec%0d_q", i), 32'(qv), 32'(vec[i].q));
      chk($sformatf("vec%0d_flags", i), 32'(fv), 32'(vec[i].f));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vec[i].lat));
    end

    // Backpressure: result held, inputs ignored until the transfer
    a = 16'h4200; b = 16'h3E00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    waitResult(lat);
    chk("bp_lat", 32'(lat), 32'd14);
    for (int i = 0; i < 5; i++) begin
      a = 16'h3C00; b = 16'h0000; in_valid = i[0];
      @(posedge clk);
      @(negedge clk);
      chk("bp_q", 32'(q), 32'h4000);
      chk("bp_flags", 32'(fl), 32'h01);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_done_out_valid", 32'(out_valid), 32'd0);
    chk("bp_done_flags", 32'(fl), 32'h0);
    chk("bp_done_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("bp_no_ghost", 32'(seen), 32'd0);

    // Reset in the middle of DIV abandons the operation
    a = 16'h3C00; b = 16'h4200; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_flags", 32'(fl), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    runOp(16'h4200, 16'h3E00, qv, fv, lat);
    chk("midrst_after_q", 32'(qv), 32'h4000);
    chk("midrst_after_flags", 32'(fv), 32'h01);
    chk("midrst_after_lat", 32'(lat), 32'd14);

    // Randomized operands against the rational reference
    for (int n = 0; n < 200; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      case ($urandom_range(0, 7))
        0: x[14:10] = 5'h00;
        1: y[14:10] = 5'h00;
        2: x[14:10] = 5'h1F;
        3: y[14:10] = y[14:10] ^ x[14:10] ^ 5'h0F;
        default: ;
      endcase
      r = refDiv(x, y);
      runOp(x, y, qv, fv, lat);
      if (qv !== r.q || fv !== r.f || lat != r.lat)
        $display("rnd operands a=%h b=%h", x, y);
      chk("rnd_q", 32'(qv), 32'(r.q));
      chk("rnd_flags", 32'(fv), 32'(r.f));
      chk("rnd_lat", 32'(lat), 32'(r.lat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_div.md
# fp16_div

Sequential IEEE 754 binary16 divider computing q = a / b, the inverse-direction companion to the team's combinational half-precision multiplier in the fpmac datapath. It uses the same special-value rules, the same six one-hot class flags and the same truncating (round-toward-zero) result packing, so quotients are bit-compatible with what the multiplier would need to invert. Division is an iterative restoring algorithm, one quotient bit per cycle, wrapped in a valid/ready handshake on both sides.

## Interface
- No parameters; format fixed to binary16 (1/5/10, bias 15).
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  16  dividend, binary16.
- b  in  16  divisor, binary16.
- out_valid  out  1  result q and flags valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- q  out  16  quotient, binary16.
- snan, qnan, infinity, zero, subnormal, normal  out  1 each  one-hot class of q; all 0 when out_valid=0.

## Operation
- States: IDLE, UNPACK, DIV, PACK, DONE.
- IDLE: in_ready=1. On in_valid, capture a, b, and go to UNPACK. in_valid while not in IDLE is ignored and not stored.
- UNPACK classifies both operands and sets sign s = a[15]^b[15]. Special cases, in priority order, go directly to PACK with a preset result:
  - either operand sNaN: q = a if a is sNaN, else b; flag snan.
  - either operand qNaN: q = a if a is qNaN, else b; flag qnan.
  - inf/inf or 0/0: q = {s,5'h1F,1'b1,9'h2A}; flag qnan.
  - a inf, or b zero (a finite, nonzero): q = {s,5'h1F,10'h0}; flag infinity.
  - a zero, or b inf: q = {s,15'h0}; flag zero.
- Otherwise UNPACK forms 11-bit significands with the leading 1 and a signed 7-bit unbiased exponent for each operand.
  - Subnormals are normalized: shift left by their leading-zero count lz; exponent = -14 - lz.
  - Result exponent e = ea - eb, range ±39.
- DIV runs exactly 12 iterations (4-bit counter 11 down to 0).
  - Initial values: R = {1'b0, sigA} (12 bits), D = sigB.
  - Each cycle: if R >= D then qbit=1 and R = R - D, else qbit=0; then R = R << 1.
  - Result: Q = floor(2048·sigA/sigB), 12 bits.
- PACK:
  - If Q[11]: sig = Q[11:1]. Else: sig = Q[10:0], e = e - 1.
  - e < -24: q = {s,15'h0}; flag zero.
  - e < -14: q = {s,5'h0,(sig >> (-14-e))[9:0]}; flag subnormal.
  - e > 15: q = {s,5'h1F,10'h0}; flag infinity.
  - else: q = {s,(e+15)[4:0],sig[9:0]}; flag normal.
  - All discarded bits are truncated; there is no rounding.
- DONE: out_valid=1; q and flags are stable. On out_ready, go to IDLE.

## Timing
- Reset (rst_n low at an edge): state IDLE, out_valid=0, q=16'h0, all flags 0, counter 0. in_ready becomes 1 the cycle after reset is released.
- Reset mid-operation abandons the operation; nothing is output.
- Acceptance at edge N (in_valid && in_ready):
  - Normal path: out_valid rises after edge N+14 (UNPACK 1, DIV 12, PACK 1).
  - Special path: out_valid rises after edge N+2.
- out_valid/out_ready:
  - The result transfers on the edge where both are high.
  - State returns to IDLE on that edge; out_valid and flags drop and in_ready rises in the following cycle.
  - No overlap of operations. Minimum issue interval is 16 cycles (normal) or 4 cycles (special).
- out_ready asserted before out_valid has no effect.
- in_ready is 0 from the acceptance edge until the output transfer completes.

## Test plan
- 0x4200 / 0x3E00 (3.0/1.5) -> q=0x4000, normal=1, out_valid exactly 14 cycles after accept.
- 0x3C00 / 0x4200 (1/3) -> q=0x3555 (truncated), normal=1.
- 0x0400 / 0x4000 -> q=0x0200, subnormal. 0x7BFF / 0x3800 -> q=0x7C00, infinity. 0x0001 / 0x3C00 -> q=0x0001, subnormal (exercises normalizing a subnormal operand).
- Specials, each out_valid 2 cycles after accept:
  - 0x3C00/0x0000 -> 0x7C00 infinity.
  - 0x0000/0x0000 -> 0x7E2A qnan.
  - 0x7D00/0x3C00 -> 0x7D00 snan.
  - 0xBC00/0x7C00 -> 0x8000 zero.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> q and flags stable, in_ready=0, in_valid pulses ignored. Then assert out_ready -> one transfer, in_ready=1 next cycle.
- Drive rst_n=0 during DIV iteration 6 -> next cycle out_valid=0, in_ready=1 after release. A new 0x4200/0x3E00 then completes correctly in 14 cycles.
